// File: rtl/fifo_uart_drain.sv
// rtl/fifo_uart_drain.sv - pops 32-bit words from a FIFO and sends each as four 8N1 UART frames.
module fifo_uart_drain #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_enable,
  input  logic             fifo_empty,
  input  logic [31:0]      fifo_data,
  output logic             fifo_rd,
  output logic             fifo_en,
  output logic             tx,
  output logic             busy,
  output logic             word_done,
  output logic [CNT_W-1:0] words_sent
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PREV = BW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {IDLE, RD, LATCH, START, DATA, STOP} state_t;

  state_t        state;
  logic [31:0]   shreg;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic          baud_end;

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign fifo_en  = fifo_rd;

  // Outputs are registered, so each transition also loads the value tx must show in the new state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      fifo_rd    <= 1'b0;
      busy       <= 1'b0;
      word_done  <= 1'b0;
      words_sent <= '0;
      shreg      <= '0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
    end else begin
      fifo_rd   <= 1'b0;
      word_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_enable && !fifo_empty) begin
            state   <= RD;
            fifo_rd <= 1'b1;
            busy    <= 1'b1;
          end
        end
        RD: state <= LATCH;
        LATCH: begin
          shreg    <= fifo_data;
          byte_idx <= '0;
          bit_idx  <= '0;
          baud_cnt <= '0;
          tx       <= 1'b0;
          state    <= START;
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            tx       <= shreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            shreg    <= shreg >> 1;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              tx      <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (byte_idx == 2'd3) begin
              busy       <= 1'b0;
              words_sent <= words_sent + CNT_W'(1);
              state      <= IDLE;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              tx       <= 1'b0;
              state    <= START;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
            // Raised one cycle early so the registered pulse lands in the last stop-bit cycle.
            if (byte_idx == 2'd3 && baud_cnt == BAUD_PREV)
              word_done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_drain.sv
// tb/tb_fifo_uart_drain.sv - scoreboard bench: FIFO model feeds the drain, a UART decoder checks the words.
module tb_fifo_uart_drain;
  localparam int C   = 4;
  localparam int LAT = 1 + 40 * C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_enable = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_data = '0;
  logic        fifo_rd, fifo_en, tx, busy, word_done;
  logic [15:0] words_sent;
  logic        rd2, en2, tx2, busy2, done2;
  logic [1:0]  ws2;

  fifo_uart_drain #(.CLKS_PER_BIT(C), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd), .fifo_en(fifo_en), .tx(tx), .busy(busy), .word_done(word_done),
    .words_sent(words_sent));

  fifo_uart_drain #(.CLKS_PER_BIT(C), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(rd2), .fifo_en(en2), .tx(tx2), .busy(busy2), .word_done(done2),
    .words_sent(ws2));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] pending;
  bit          pending_valid = 0;

  // FIFO model: data follows a read pulse by one cycle; garbage otherwise.
  initial forever begin
    @(posedge clk);
    #2;
    if (pending_valid) begin
      fifo_data = pending;
      pending_valid = 0;
    end else begin
      fifo_data = $urandom;
    end
    if (fifo_rd && !rst) begin
      chk("no_underflow", fifo_q.size() > 0, 1);
      if (fifo_q.size() > 0) begin
        pending = fifo_q.pop_front();
        pending_valid = 1;
        exp_q.push_back(pending);
      end
    end
    fifo_empty = (fifo_q.size() == 0);
  end

  int cyc = 0, pops = 0, dones = 0, words_model = 0;
  int rx_t = 0, rx_nbytes = 0, rx_nwords = 0, j;
  bit word_open = 0, rx_active = 0, rst_prev = 0, ws_pending = 0;
  logic [7:0]  rx_byte;
  logic [31:0] rx_word, last_word = '0;
  int rd_q[$], rd_log[$], done_log[$], ws2_log[$];

  // Monitor: protocol checks, UART decode against the scoreboard, word count model.
  always @(negedge clk) begin
    cyc++;
    if (ws_pending) begin
      chk("words_sent", words_sent, words_model % 65536);
      chk("words_sent_w2", ws2, words_model % 4);
      ws2_log.push_back(int'(ws2));
      ws_pending = 0;
    end
    if (rst_prev) begin
      chk("reset_outputs", {tx, busy, fifo_rd, fifo_en, word_done}, 5'b10000);
      chk("reset_words_sent", words_sent, 0);
      chk("reset_words_sent_w2", ws2, 0);
    end
    rst_prev = rst;
    if (rst) begin
      word_open = 0; rx_active = 0; rx_nbytes = 0; rx_nwords = 0;
      pops = 0; dones = 0; words_model = 0; ws_pending = 0;
      exp_q.delete(); rd_q.delete(); rd_log.delete(); done_log.delete(); ws2_log.delete();
    end else begin
      chk("fifo_en_eq_rd", fifo_en, fifo_rd);
      if (fifo_rd) begin
        chk("single_read_per_word", word_open, 0);
        word_open = 1;
        pops++;
        rd_q.push_back(cyc);
        rd_log.push_back(cyc);
      end
      chk("busy", busy, word_open);
      if (!word_open) chk("tx_idle_high", tx, 1);
      if (!rx_active) begin
        if (tx == 1'b0) begin
          rx_active = 1;
          rx_t = 0;
        end
      end else begin
        rx_t++;
      end
      if (rx_active && (rx_t % C) == C / 2) begin
        j = rx_t / C;
        if (j == 0) chk("start_bit", tx, 0);
        else if (j <= 8) rx_byte[j-1] = tx;
        else begin
          chk("stop_bit", tx, 1);
          rx_active = 0;
          rx_word = {rx_byte, rx_word[31:8]};
          rx_nbytes++;
          if (rx_nbytes == 4) begin
            chk("scoreboard_has_word", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk("rx_word", rx_word, exp_q.pop_front());
            last_word = rx_word;
            rx_nbytes = 0;
            rx_nwords++;
          end
        end
      end
      if (word_done) begin
        chk("done_latency", (rd_q.size() > 0) ? cyc - rd_q.pop_front() : -1, LAT);
        dones++;
        chk("done_after_4_bytes", rx_nwords, dones);
        done_log.push_back(cyc);
        words_model++;
        ws_pending = 1;
        word_open = 0;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    fifo_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic wait_dones(input int n, input int budget);
    for (int i = 0; i < budget && dones < n; i++) @(posedge clk);
    chk("dones_reached", dones >= n, 1);
  endtask

  task automatic wait_pops(input int n, input int budget);
    for (int i = 0; i < budget && pops < n; i++) @(posedge clk);
    chk("pops_reached", pops >= n, 1);
  endtask

  int rel_cyc;
  logic [31:0] w;
  int exp_ws2[5] = '{1, 2, 3, 0, 1};

  initial begin
    // Reset held with an empty FIFO: nothing may be read.
    tx_enable = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (50) @(posedge clk);
    #1;
    chk("idle_pops", pops, 0);
    chk("idle_tx_busy", {tx, busy}, 2'b10);

    // Single known word.
    fifo_q.push_back(32'hA55A_0F31);
    wait_dones(1, 400);
    repeat (3) @(posedge clk);
    #1;
    chk("single_pops", pops, 1);
    chk("single_word", last_word, 32'hA55A_0F31);
    chk("single_words_sent", words_sent, 1);

    // Three queued words sent back to back.
    do_reset();
    for (int i = 0; i < 3; i++) fifo_q.push_back($urandom);
    wait_dones(3, 1000);
    repeat (100) @(posedge clk);
    #1;
    chk("b2b_pops", pops, 3);
    chk("b2b_words_sent", words_sent, 3);
    for (int i = 0; i < 2; i++)
      chk("b2b_gap", (rd_log.size() > i + 1 && done_log.size() > i) ? rd_log[i+1] - done_log[i] : -1, 2);

    // tx_enable dropped during byte 1: the word finishes, then no more reads.
    do_reset();
    for (int i = 0; i < 3; i++) fifo_q.push_back($urandom);
    wait_pops(1, 50);
    repeat (2 + 12 * C) @(posedge clk);
    #1 tx_enable = 0;
    wait_dones(1, 400);
    repeat (300) @(posedge clk);
    #1;
    chk("disable_pops", pops, 1);
    chk("disable_dones", dones, 1);
    chk("disable_fifo_left", fifo_q.size(), 2);
    chk("disable_words_sent", words_sent, 1);
    tx_enable = 1;

    // Reset during DATA of byte 2: the aborted word is dropped, the next word is sent cleanly.
    do_reset();
    fifo_q.push_back($urandom);
    w = $urandom;
    fifo_q.push_back(w);
    wait_pops(1, 50);
    repeat (90) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    rel_cyc = cyc;
    chk("midrst_tx_busy", {tx, busy}, 2'b10);
    chk("midrst_words_sent", words_sent, 0);
    wait_dones(1, 400);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_restart", (rd_log.size() > 0) ? rd_log[0] - rel_cyc : -1, 2);
    chk("midrst_word", last_word, w);
    chk("midrst_words_sent_after", words_sent, 1);

    // Narrow counter wraps.
    do_reset();
    for (int i = 0; i < 5; i++) fifo_q.push_back($urandom);
    wait_dones(5, 1500);
    repeat (3) @(posedge clk);
    chk("wrap_log_len", ws2_log.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("wrap_seq", (ws2_log.size() > i) ? ws2_log[i] : -1, exp_ws2[i]);

    // Random arrivals with tx_enable toggling.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 200)) @(posedge clk);
      #1;
      fifo_q.push_back($urandom);
      tx_enable = ($urandom_range(0, 3) != 0);
    end
    #1 tx_enable = 1;
    wait_dones(8, 3000);
    repeat (5) @(posedge clk);
    chk("random_dones", dones, 8);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
